// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the RV32I core.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: rst > flush > stall > load.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0}
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst)         q <= BUBBLE;
    else if (flush)  q <= BUBBLE;
    else if (!stall) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, 1-entry skid buffer
// and the IF/ID register.
module fetch_stage #(
  parameter int unsigned             DATA_LENGTH = 32,
  parameter logic [DATA_LENGTH-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [DATA_LENGTH-1:0]  NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_f,
  input  logic                   stall_d,
  input  logic                   flush_d,
  input  logic                   pc_src_e,
  input  logic [DATA_LENGTH-1:0] pc_target_e,
  output logic                   imem_req,
  output logic [DATA_LENGTH-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [DATA_LENGTH-1:0] imem_rdata,
  output logic [DATA_LENGTH-1:0] instr_d,
  output logic [DATA_LENGTH-1:0] pc_d,
  output logic [DATA_LENGTH-1:0] pc_plus4_d,
  output logic                   valid_d,
  output logic                   fetch_busy
);
  import pipeline_pkg::*;

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  fetch_state_t           state, state_nx;
  logic [DATA_LENGTH-1:0] pc_f, pc_f_nx;
  logic [DATA_LENGTH-1:0] req_addr, req_addr_nx;
  logic [DATA_LENGTH-1:0] redirect_pc, pc_plus4_f;
  if_id_t                 buf_q, buf_nx, if_id_nx, if_id_q;
  if_id_t                 fetched;
  logic                   xfer, can_accept;

  assign imem_req    = (state == WAIT) || (state == DROP);
  assign imem_addr   = req_addr;
  assign xfer        = imem_req && imem_ready;
  assign fetch_busy  = imem_req && !imem_ready;
  assign redirect_pc = pc_target_e & ~32'd3;
  assign pc_plus4_f  = pc_f + 32'd4;
  assign can_accept  = !stall_d && !flush_d;
  assign fetched     = '{instr: imem_rdata, pc: req_addr, pc_plus4: req_addr + 32'd4, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_f     <= RESET_PC;
      req_addr <= RESET_PC;
      buf_q    <= BUBBLE;
    end else begin
      state    <= state_nx;
      pc_f     <= pc_f_nx;
      req_addr <= req_addr_nx;
      buf_q    <= buf_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_f_nx     = pc_f;
    req_addr_nx = req_addr;
    buf_nx      = buf_q;
    if_id_nx    = BUBBLE;
    case (state)
      IDLE: begin
        if (pc_src_e) pc_f_nx = redirect_pc;
        // A redirect arriving here is fetched directly so no stale request is issued.
        if (!stall_f) begin
          req_addr_nx = pc_src_e ? redirect_pc : pc_f;
          state_nx    = WAIT;
        end
      end
      WAIT: begin
        if (pc_src_e) begin
          pc_f_nx  = redirect_pc;
          state_nx = xfer ? IDLE : DROP;
        end else if (xfer) begin
          pc_f_nx = pc_plus4_f;
          if (can_accept) begin
            if_id_nx = fetched;
            if (!stall_f) req_addr_nx = pc_plus4_f;
            else          state_nx    = IDLE;
          end else begin
            buf_nx   = fetched;
            state_nx = HOLD;
          end
        end
      end
      DROP: begin
        if (pc_src_e) pc_f_nx = redirect_pc;
        if (xfer)     state_nx = IDLE;
      end
      HOLD: begin
        if (pc_src_e) begin
          pc_f_nx      = redirect_pc;
          buf_nx.valid = 1'b0;
          state_nx     = IDLE;
        end else if (!stall_d) begin
          if_id_nx     = buf_q;
          buf_nx.valid = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  if_id_reg #(.BUBBLE(BUBBLE)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_d),
    .stall (stall_d),
    .d     (if_id_nx),
    .q     (if_id_q)
  );

  assign instr_d    = if_id_q.instr;
  assign pc_d       = if_id_q.pc;
  assign pc_plus4_d = if_id_q.pc_plus4;
  assign valid_d    = if_id_q.valid;

endmodule
